// File: rtl/reg_wb_queue.sv
// Write-back queue: merges ALU and load results into one register-file write port, strict FIFO order.
// Latency: accept at edge E -> RegWrite during cycle after E+1 (after E with WB_QUEUE_BYPASS_EN when empty).
// Backpressure: mem_ready = !full, alu_ready = !full && !mem_valid; no enqueue while full.
//
// Optional feature macro: WB_QUEUE_BYPASS_EN (empty-queue bypass straight into the output register).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result source (lower priority)
//   mem_valid/mem_ready/mem_rd/mem_data  load result source (higher priority)
//   w_reg, w_data, RegWrite            register-file write port (registered)
//   pend_mask                          registers with a write queued or being presented
//   count, full, empty                 FIFO occupancy (registered)
module reg_wb_queue #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic [4:0]    w_reg,
    output logic [DW-1:0] w_data,
    output logic          RegWrite,
    output logic [31:0]   pend_mask,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } entry_t;

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic [4:0]    w_reg_q;
    logic [DW-1:0] w_data_q;
    logic          regwrite_q;

    entry_t        in_ent;
    logic          acc, store, bypass, push, pop;
    logic [31:0]   pend_d;
    logic [AW-1:0] idx;

    // Ready is derived from the registered full flag only, so a same-cycle
    // dequeue never opens a slot early.
    assign mem_ready = !full_q;
    assign alu_ready = !full_q && !mem_valid;

    // The load path wins whenever it is valid; at most one enqueue per cycle.
    assign acc    = (mem_valid || alu_valid) && !full_q;
    assign in_ent = mem_valid ? entry_t'{rd: mem_rd, data: mem_data}
                              : entry_t'{rd: alu_rd, data: alu_data};
    // Writes to X31 (zero register) are accepted but dropped.
    assign store  = acc && (in_ent.rd != 5'd31);

`ifdef WB_QUEUE_BYPASS_EN
    assign bypass = store && empty_q;
`else
    assign bypass = 1'b0;
`endif

    assign push = store && !bypass;
    assign pop  = !empty_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            w_reg_q    <= '0;
            w_data_q   <= '0;
            regwrite_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_MAX);
            empty_q <= (count_d == '0);

            // Output register reloads every edge; address/data hold when idle.
            if (pop) begin
                w_reg_q    <= mem_q[rd_ptr_q].rd;
                w_data_q   <= mem_q[rd_ptr_q].data;
                regwrite_q <= 1'b1;
            end else if (bypass) begin
                w_reg_q    <= in_ent.rd;
                w_data_q   <= in_ent.data;
                regwrite_q <= 1'b1;
            end else begin
                regwrite_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_ent;
    end

    // Pending mask: every live FIFO slot plus the write being presented.
    always_comb begin
        pend_d = '0;
        idx    = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if ((AW+1)'(i) < count_q) pend_d[mem_q[idx].rd] = 1'b1;
        end
        if (regwrite_q) pend_d[w_reg_q] = 1'b1;
        pend_d[31] = 1'b0;
    end

    assign pend_mask = pend_d;
    assign w_reg     = w_reg_q;
    assign w_data    = w_data_q;
    assign RegWrite  = regwrite_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule
